// File: rtl/epp_host.sv
// rtl/epp_host.sv - EPP host cycle engine; optional abort timer enabled by EPP_HOST_TIMEOUT_EN
module epp_host #(
    parameter int SETUP_CYCLES   = 2,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_addr,
    input  logic       cmd_read,
    input  logic [7:0] cmd_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       rsp_timeout,
    output logic       busy,
    output logic       EPP_ASTB,
    output logic       EPP_DSTB,
    output logic       EPP_WR,
    inout  wire  [7:0] EPP_D,
    input  logic       EPP_WAIT
);

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_STROBE, S_RELEASE} state_t;

    // An out-of-range configuration never accepts work rather than misbehaving on the bus.
    localparam bit CFG_OK = (SETUP_CYCLES >= 1) && (SETUP_CYCLES <= 15) &&
                            (TIMEOUT_CYCLES >= 1) && (TIMEOUT_CYCLES <= 65535);
    localparam logic [3:0] SETUP_LOAD = 4'(SETUP_CYCLES - 1);

    state_t      state_q;
    logic        wait_m_q, wait_s_q;
    logic [7:0]  d_m_q, d_s_q;
    logic        addr_q, read_q;
    logic [3:0]  setup_cnt_q;
    logic        astb_q, dstb_q, wr_q, d_oe_q;
    logic [7:0]  d_out_q, rdata_q;
    logic        done_ok;
    logic        timeout_hit;

    // Two-flop synchronizers for the asynchronous responder signals.
    always_ff @(posedge CLK) begin
        if (RST) begin
            wait_m_q <= 1'b0;
            wait_s_q <= 1'b0;
            d_m_q    <= 8'h00;
            d_s_q    <= 8'h00;
        end else begin
            wait_m_q <= EPP_WAIT;
            wait_s_q <= wait_m_q;
            d_m_q    <= EPP_D;
            d_s_q    <= d_m_q;
        end
    end

`ifdef EPP_HOST_TIMEOUT_EN
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] tmo_cnt_q;

    // The abort fires in the last allowed cycle so the wait phase lasts exactly TIMEOUT_CYCLES.
    assign timeout_hit = ((state_q == S_STROBE) || (state_q == S_RELEASE)) && (tmo_cnt_q == TMO_LAST);
    assign rsp_timeout = !RST && timeout_hit;

    // Wait-phase timer: held at zero until STROBE, restarted on the STROBE->RELEASE edge.
    always_ff @(posedge CLK) begin
        if (RST) begin
            tmo_cnt_q <= 16'd0;
        end else if ((state_q == S_SETUP) || ((state_q == S_STROBE) && wait_s_q)) begin
            tmo_cnt_q <= 16'd0;
        end else if ((state_q == S_STROBE) || (state_q == S_RELEASE)) begin
            tmo_cnt_q <= tmo_cnt_q + 16'd1;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign rsp_timeout = 1'b0;
`endif

    // Completion coincides with the RELEASE->IDLE edge, so no request can be taken in that cycle.
    assign done_ok   = (state_q == S_RELEASE) && !wait_s_q;
    assign rsp_valid = !RST && (done_ok || timeout_hit);
    assign cmd_ready = !RST && CFG_OK && (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign rsp_rdata = rdata_q;
    assign EPP_ASTB  = astb_q;
    assign EPP_DSTB  = dstb_q;
    assign EPP_WR    = wr_q;
    assign EPP_D     = d_oe_q ? d_out_q : 8'hzz;

    // Bus cycle sequencer; all pin levels change only on state transitions.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= S_IDLE;
            astb_q      <= 1'b1;
            dstb_q      <= 1'b1;
            wr_q        <= 1'b1;
            d_oe_q      <= 1'b0;
            d_out_q     <= 8'h00;
            addr_q      <= 1'b0;
            read_q      <= 1'b0;
            setup_cnt_q <= 4'd0;
            rdata_q     <= 8'h00;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (cmd_valid && CFG_OK) begin
                        addr_q      <= cmd_addr;
                        read_q      <= cmd_read;
                        d_out_q     <= cmd_wdata;
                        wr_q        <= cmd_read;
                        d_oe_q      <= !cmd_read;
                        setup_cnt_q <= SETUP_LOAD;
                        state_q     <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    if (setup_cnt_q == 4'd0) begin
                        astb_q  <= !addr_q;
                        dstb_q  <= addr_q;
                        state_q <= S_STROBE;
                    end else begin
                        setup_cnt_q <= setup_cnt_q - 4'd1;
                    end
                end
                S_STROBE: begin
                    if (timeout_hit) begin
                        astb_q  <= 1'b1;
                        dstb_q  <= 1'b1;
                        wr_q    <= 1'b1;
                        d_oe_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else if (wait_s_q) begin
                        if (read_q) begin
                            rdata_q <= d_s_q;
                        end
                        astb_q  <= 1'b1;
                        dstb_q  <= 1'b1;
                        state_q <= S_RELEASE;
                    end
                end
                S_RELEASE: begin
                    if (timeout_hit || !wait_s_q) begin
                        wr_q    <= 1'b1;
                        d_oe_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/epp_host.md
EPP_HOST -- requirements
Module: epp_host

Interface
REQ-001 Parameter SETUP_CYCLES, default 2: CLK cycles that EPP_WR and EPP_D are held stable before a strobe falls; legal range 1..15.
REQ-002 Parameter TIMEOUT_CYCLES, default 1023: CLK cycles allowed per handshake wait phase; legal range 1..65535.
REQ-003 CLK  in  1  sole clock; every register is updated on its rising edge.
REQ-004 RST  in  1  reset; synchronous, active-high.
REQ-005 cmd_valid  in  1  request present.
REQ-006 cmd_ready  out  1  host can accept a request.
REQ-007 cmd_addr  in  1  1 = address cycle (ASTB); 0 = data cycle (DSTB).
REQ-008 cmd_read  in  1  1 = read; 0 = write.
REQ-009 cmd_wdata  in  8  write byte.
REQ-010 rsp_valid  out  1  one-cycle completion pulse.
REQ-011 rsp_rdata  out  8  read byte; holds its value until the next rsp_valid.
REQ-012 rsp_timeout  out  1  qualifies rsp_valid: the cycle was aborted.
REQ-013 busy  out  1  high whenever the state is not IDLE.
REQ-014 EPP_ASTB, EPP_DSTB  out  1 each  active-low strobes.
REQ-015 EPP_WR  out  1  0 = write, 1 = read.
REQ-016 EPP_D  inout  8  bus; driven only while a write cycle is active, otherwise high-Z.
REQ-017 EPP_WAIT  in  1  responder handshake; asynchronous to CLK.

Function
REQ-018 EPP_WAIT and EPP_D SHALL each pass through a 2-flop synchronizer; all decisions use the synchronized copies (wait_s, d_s).
REQ-019 States SHALL be IDLE, SETUP, STROBE, RELEASE.
REQ-020 IDLE: cmd_ready=1; on cmd_valid, latch cmd_addr, cmd_read and cmd_wdata, load the setup counter, and go to SETUP next cycle.
REQ-021 SETUP: EPP_WR=cmd_read; EPP_D drives the latched byte if write; both strobes high; after exactly SETUP_CYCLES cycles go to STROBE.
REQ-022 STROBE: the selected strobe (ASTB if cmd_addr, else DSTB) is low and the other is high; when wait_s==1, capture d_s into rsp_rdata if read, then go to RELEASE.
REQ-023 RELEASE: both strobes high; EPP_D and EPP_WR are held from SETUP; when wait_s==0, pulse rsp_valid with rsp_timeout=0, go to IDLE, return EPP_WR to 1, and tri-state EPP_D.
REQ-024 cmd_ready SHALL be 0 outside IDLE; cmd_valid is ignored there and never queued.
REQ-025 A request accepted in the same cycle as rsp_valid is impossible, because rsp_valid coincides with the transition into IDLE.
REQ-026 With a responder that answers combinationally, strobe low SHALL last exactly 3 cycles, from first assertion through the sampling edge of wait_s==1.
REQ-027 A write cycle SHALL never update rsp_rdata.
REQ-028 At most one strobe SHALL be low in any cycle, and neither strobe may be low while EPP_WR changes.

Reset
REQ-029 RST SHALL force IDLE, EPP_ASTB=EPP_DSTB=EPP_WR=1, EPP_D high-Z, rsp_valid=0, rsp_timeout=0, rsp_rdata=0, busy=0, cmd_ready=0 during the reset cycle, counters 0, and both synchronizers to 0.
REQ-030 RST asserted mid-cycle SHALL abort the cycle immediately with strobes high and no rsp_valid.

Configuration
REQ-031 With macro EPP_HOST_TIMEOUT_EN defined, a 16-bit counter SHALL clear on entry to STROBE and to RELEASE and increment each cycle in those states.
REQ-032 If that counter reaches TIMEOUT_CYCLES, the host SHALL raise both strobes, tri-state EPP_D, set EPP_WR=1, pulse rsp_valid with rsp_timeout=1 leaving rsp_rdata unchanged, and return to IDLE.
REQ-033 Without EPP_HOST_TIMEOUT_EN, no counter is built, rsp_timeout is constant 0, and the host waits indefinitely in STROBE or RELEASE.

Verification
REQ-034 Address write 0x0D with a responder model raising WAIT 1 cycle after ASTB falls -> ASTB low, DSTB high, EPP_WR=0, EPP_D=0x0D through RELEASE; one rsp_valid; rsp_timeout=0.
REQ-035 Data read with the responder driving 0xA5 and raising WAIT -> rsp_rdata=0xA5 at rsp_valid; EPP_D never driven by the host; EPP_WR=1 throughout.
REQ-036 Back-to-back commands: cmd_valid held high for 4 requests -> exactly 4 rsp_valid pulses; cmd_ready high only in IDLE; no two strobes ever low together.
REQ-037 Macro defined, TIMEOUT_CYCLES=8, responder never raises WAIT -> strobe low for exactly 8 cycles, then rsp_valid with rsp_timeout=1; next command completes normally.
REQ-038 RST pulsed while DSTB is low -> next cycle DSTB=1, EPP_D high-Z, no rsp_valid; a subsequent write completes normally.
REQ-039 Responder holds WAIT high for 20 cycles after the strobe rises -> host stays in RELEASE for those 20 cycles and rsp_valid fires 2 cycles after WAIT falls.
